// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg: opcodes, opcode classes and memory-FSM state encodings for the LC3 pipe sequencer
package lc3_ctrl_pkg;
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;
  // low two bits are the externally visible mem_state code
  typedef enum logic [2:0] {
    MS_RD   = 3'b000,
    MS_IND  = 3'b001,
    MS_WR   = 3'b010,
    MS_IDLE = 3'b011,
    MS_WB   = 3'b111
  } mem_fsm_t;
  function automatic logic mem_op(input logic [3:0] op);
    return op inside {OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI};
  endfunction
  function automatic logic wb_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
  endfunction
  function automatic logic ctrl_op(input logic [3:0] op);
    return op inside {OP_BR, OP_JMP};
  endfunction
  function automatic logic ind_op(input logic [3:0] op);
    return op inside {OP_LDI, OP_STI};
  endfunction
  function automatic logic store_op(input logic [3:0] op);
    return op inside {OP_ST, OP_STR, OP_STI};
  endfunction
endpackage

// File: rtl/lc3_mem_fsm.sv
// lc3_mem_fsm: data-memory access sequencer that freezes the pipe while a load/store is in writeback
module lc3_mem_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       complete_data,
  input  logic       vw,
  input  logic [3:0] op,
  output logic       stall,
  output logic [1:0] mem_state,
  output logic       wb_pulse,
  output logic       retire
);
  mem_fsm_t state;
  logic store;
  logic hit;
  assign hit       = vw & mem_op(op) & (state == MS_IDLE);
  assign stall     = (state != MS_IDLE) | hit;
  assign mem_state = state[1:0];
  assign wb_pulse  = state == MS_WB;
  assign retire    = ((state == MS_WR) & complete_data) | wb_pulse;
  // access sequencing; the store flag remembers which way an indirect access continues
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= MS_IDLE;
      store <= 1'b0;
    end else
      case (state)
        MS_IDLE: if (hit) begin
          store <= store_op(op);
          state <= ind_op(op) ? MS_IND : store_op(op) ? MS_WR : MS_RD;
        end
        MS_IND:  if (complete_data) state <= store ? MS_WR : MS_RD;
        MS_RD:   if (complete_data) state <= MS_WB;
        MS_WR:   if (complete_data) state <= MS_IDLE;
        default: state <= MS_IDLE;
      endcase
endmodule

// File: rtl/lc3_pipe_ctrl.sv
// lc3_pipe_ctrl: LC3 pipeline sequencer producing per-stage enables from slot occupancy
module lc3_pipe_ctrl
  import lc3_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_data,
  input  logic [15:0] instr_dout,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state
);
  logic vd, ve, vw, ctrl_pend;
  logic stall, wb_pulse, retire, resolve;
  logic [3:0] op_d, op_w;
  logic unused_bits;
  assign op_d        = instr_dout[15:12];
  assign op_w        = IR_Exec[15:12];
  assign unused_bits = ^{instr_dout[11:0], IR_Exec[8:0]};
  lc3_mem_fsm u_mem (
    .clock        (clock),
    .reset        (reset),
    .complete_data(complete_data),
    .vw           (vw),
    .op           (op_w),
    .stall        (stall),
    .mem_state    (mem_state),
    .wb_pulse     (wb_pulse),
    .retire       (retire)
  );
  assign resolve          = vw & !stall & ctrl_op(op_w);
  assign enable_fetch     = !stall & !ctrl_pend;
  assign enable_updatePC  = enable_fetch;
  assign enable_decode    = vd & !stall;
  assign enable_execute   = ve & !stall;
  assign enable_writeback = (vw & !stall & wb_op(op_w)) | wb_pulse;
  // slot occupancy shifts when free-running; a branch in decode blocks fetch even under a stall
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      vd        <= 1'b0;
      ve        <= 1'b0;
      vw        <= 1'b0;
      ctrl_pend <= 1'b0;
      br_taken  <= 1'b0;
    end else begin
      if (!stall) begin
        vd <= enable_fetch;
        ve <= vd;
        vw <= ve;
      end else if (retire)
        vw <= 1'b0;
      ctrl_pend <= (vd & ctrl_op(op_d)) | (ctrl_pend & !resolve);
      if (resolve) br_taken <= (op_w == OP_JMP) | (|(IR_Exec[11:9] & psr));
    end
endmodule
